regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with a write-first bypass and an integrated scoreboard for the pipelined core.
//  Register ZERO_REG is hardwired to 0 (XZR). Issue marks a destination busy, and writeback clears it.
//  Per-port busy flags let decode stall on RAW hazards. The issue handshake stalls on WAW hazards and on outstanding-write overflow.
// PARAMETERS
//  WIDTH     64  data width of each register
//  NREGS     32  number of registers (power of 2); AW = $clog2(NREGS)
//  NRD       2   number of read ports
//  ZERO_REG  31  index that always reads 0 and ignores writes
//  MAX_PEND  4   max outstanding scheduled writes (>=1)
//  BYPASS    1   1: a same-cycle write is forwarded to reads; 0: reads return the old value
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           asynchronous, active-high reset
//  ra        in   NRD*AW      read addresses, port k = ra[k*AW +: AW]
//  rd        out  NRD*WIDTH   read data, port k = rd[k*WIDTH +: WIDTH]
//  rd_busy   out  NRD         port k source has a pending, not-yet-forwarded write
//  we        in   1           writeback enable
//  wa        in   AW          writeback address
//  wd        in   WIDTH       writeback data
//  iss_valid in   1           decode requests to schedule a write to iss_dst
//  iss_dst   in   AW          destination register of the issuing instruction
//  iss_ready out  1           issue accepted this cycle when iss_valid && iss_ready
//  pend_cnt  out  $clog2(MAX_PEND+1)  number of outstanding scheduled writes
// BEHAVIOUR
//  - Reset (async, active-high): regs[i] = i for i != ZERO_REG, and regs[ZERO_REG] = 0.
//    busy[] = 0 and pend_cnt = 0. With ra = 0, rd reads 0 and rd_busy = 0.
//  - Read ports: combinational, 0-cycle latency.
//    If ra[k] == ZERO_REG, then rd = 0 and rd_busy[k] = 0.
//    Else if BYPASS && we && wa == ra[k], then rd = wd and rd_busy[k] = 0.
//    Else rd = regs[ra[k]] and rd_busy[k] = busy[ra[k]].
//  - Write: at posedge clk, when we && wa != ZERO_REG, regs[wa] <= wd. Writes to ZERO_REG are dropped silently.
//  - iss_ready = !(busy[iss_dst] && !(we && wa == iss_dst)) && (pend_cnt < MAX_PEND || (we && busy[wa])).
//    iss_ready is combinational and independent of iss_valid.
//    An issue to ZERO_REG is always ready and never sets busy or changes pend_cnt.
//  - Scoreboard update at posedge, where acc = iss_valid && iss_ready && iss_dst != ZERO_REG and clr = we && busy[wa]:
//    - busy[iss_dst] is set on acc; busy[wa] is cleared on clr.
//    - If acc and clr hit the same register, set wins (the new producer owns it).
//    - pend_cnt += acc - clr. It never wraps and holds at MAX_PEND.
//  - A write to a non-busy register (we && !busy[wa]) updates data only. pend_cnt is unchanged.
//  - Reset mid-operation discards all pending writes. The next edge after deassertion behaves as the first cycle.
// STRUCTURE
//  - Package regfile_pkg holds the ZERO_REG default, the reg-index typedef regidx_t (logic [AW-1:0]), and the reset-value function init_val(i).
//  - Sub-module regfile_scoreboard holds busy[], pend_cnt and the iss_ready logic.
//    Ports: clk, reset, iss_valid, iss_dst, we, wa, busy_vec, iss_ready, pend_cnt.
//  - The top level holds the storage array, the read muxes and the bypass logic. Read ports use a generate loop over NRD.
// TESTING
//  1. Reset, then set ra = {5,31}. Expect rd = {5,0} and rd_busy = 0. Assert reset mid-test with busy set: busy and pend_cnt clear asynchronously.
//  2. Write we=1, wa=3, wd=0xDEAD with ra0 = 3 in the same cycle (BYPASS=1). Expect rd0 = 0xDEAD that cycle and in the next.
//     With BYPASS=0, rd0 = 3 first, then 0xDEAD.
//  3. Write wa = 31, wd = 0xFFFF. Expect rd(31) = 0 on the following cycle and pend_cnt unchanged.
//  4. Issue dst = 7, then ra0 = 7. Expect rd_busy0 = 1 and pend_cnt = 1.
//     A second issue to 7 gives iss_ready = 0. Writeback wa = 7 gives busy clear and pend_cnt = 0.
//  5. Issue dst 1, 2, 3, 4. pend_cnt = 4 and iss_ready = 0 for dst 5.
//     Same-cycle writeback wa = 1 with issue dst 5: accepted, pend_cnt stays 4.
//  6. Same cycle: writeback wa = 9 (busy) and issue dst 9. Expect iss_ready = 1, busy[9] = 1 after the edge, and pend_cnt unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with scoreboard: default zero-register
// index, register index type and the reset contents of the storage array.
package regfile_pkg;

  localparam int ZERO_REG_DEF = 31;
  localparam int NREGS_DEF    = 32;
  localparam int AW_DEF       = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] regidx_t;

  // Each register powers up holding its own index; the caller forces the zero register.
  function automatic logic [63:0] init_val(input int unsigned i);
    return 64'(i);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding scheduled write and
// gates issue on WAW hazards and on the outstanding-write limit.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  parameter int MAX_PEND = 4,
  parameter int AW       = $clog2(NREGS),
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_dst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  output logic [NREGS-1:0] busy_vec,
  output logic             iss_ready,
  output logic [CW-1:0]    pend_cnt
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic             dst_zero, waw, room, acc, clr;

  assign dst_zero = iss_dst == AW'(ZERO_REG);
  assign clr      = we && busy_q[wa];
  // A writeback retiring the destination in the same cycle resolves the WAW hazard.
  assign waw      = busy_q[iss_dst] && !(we && wa == iss_dst);
  assign room     = (pend_q < CW'(MAX_PEND)) || clr;
  assign iss_ready = dst_zero || (!waw && room);
  assign acc      = iss_valid && iss_ready && !dst_zero;

  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    if (clr) busy_d[wa] = 1'b0;
    if (acc) busy_d[iss_dst] = 1'b1;  // set after clear: new producer owns the register
    if (acc && !clr && pend_q != CW'(MAX_PEND))
      pend_d = pend_q + 1'b1;
    else if (!acc && clr && pend_q != '0)
      pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with optional write-first bypass, a hardwired
// zero register and an integrated scoreboard for RAW/WAW hazard tracking.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int MAX_PEND = 4,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_dst,
  output logic                 iss_ready,
  output logic [CW-1:0]        pend_cnt
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_vec;

  always_comb begin
    regs_d = regs_q;
    if (we && wa != AW'(ZERO_REG)) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == ZERO_REG) ? '0 : WIDTH'(init_val(i));
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          zero, hit;
    assign a    = ra[k*AW +: AW];
    assign zero = a == AW'(ZERO_REG);
    assign hit  = (BYPASS != 0) && we && (wa == a);
    assign rd[k*WIDTH +: WIDTH] = zero ? '0 : (hit ? wd : regs_q[a]);
    // A forwarded value is already available, so it no longer counts as pending.
    assign rd_busy[k] = !zero && !hit && busy_vec[a];
  end

  regfile_scoreboard #(
    .NREGS(NREGS), .ZERO_REG(ZERO_REG), .MAX_PEND(MAX_PEND), .AW(AW), .CW(CW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_valid(iss_valid),
    .iss_dst  (iss_dst),
    .we       (we),
    .wa       (wa),
    .busy_vec (busy_vec),
    .iss_ready(iss_ready),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed hazard scenarios then randomized traffic, checked
// against an array-based reference model (bypass and no-bypass instances).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic          clk = 0, reset = 1;
  logic [9:0]    ra = '0;
  logic          we = 0, iss_valid = 0;
  regidx_t       wa = '0, iss_dst = '0;
  logic [63:0]   wd = '0;
  logic [127:0]  rd_a, rd_b;
  logic [1:0]    busy_a, busy_b;
  logic          rdy_a, rdy_b;
  logic [2:0]    pend_a, pend_b;

  int n_vec = 0, n_err = 0;

  logic [63:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_a), .rd_busy(busy_a), .we(we), .wa(wa), .wd(wd),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(rdy_a), .pend_cnt(pend_a));

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rd_busy(busy_b), .we(we), .wa(wa), .wd(wd),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(rdy_b), .pend_cnt(pend_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outstanding writes are exactly the registers currently marked busy.
  function automatic int m_pend();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [63:0] e_rd(input regidx_t a, input bit byp);
    if (a == 31) return 64'd0;
    if (byp && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit e_busy(input regidx_t a, input bit byp);
    if (a == 31) return 1'b0;
    if (byp && we && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit e_ready();
    if (iss_dst == 31) return 1'b1;
    if (m_busy[iss_dst] && !(we && wa == iss_dst)) return 1'b0;
    return (m_pend() < 4) || (we && m_busy[wa]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = (i == 31) ? 64'd0 : 64'(i);
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      regidx_t a;
      a = ra[k*5 +: 5];
      chk("rd_byp",     rd_a[k*64 +: 64], e_rd(a, 1'b1));
      chk("rd_nobyp",   rd_b[k*64 +: 64], e_rd(a, 1'b0));
      chk("busy_byp",   64'(busy_a[k]),   64'(e_busy(a, 1'b1)));
      chk("busy_nobyp", 64'(busy_b[k]),   64'(e_busy(a, 1'b0)));
    end
    chk("iss_ready",    64'(rdy_a),  64'(e_ready()));
    chk("iss_ready_nb", 64'(rdy_b),  64'(e_ready()));
    chk("pend_cnt",     64'(pend_a), 64'(m_pend()));
    chk("pend_cnt_nb",  64'(pend_b), 64'(m_pend()));
  endtask

  task automatic model_step();
    bit r, clr, acc;
    r   = e_ready();
    clr = we && m_busy[wa];
    acc = iss_valid && r && iss_dst != 31;
    if (we && wa != 31) m_regs[wa] = wd;
    if (clr) m_busy[wa] = 1'b0;
    if (acc) m_busy[iss_dst] = 1'b1;
  endtask

  task automatic step(input bit w, input int a, input logic [63:0] d,
                      input bit iv, input int dst, input int r0, input int r1);
    @(negedge clk);
    we = w; wa = 5'(a); wd = d; iss_valid = iv; iss_dst = 5'(dst);
    ra = {5'(r1), 5'(r0)};
    #1 check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset(input int r0, input int r1);
    @(negedge clk);
    we = 0; iss_valid = 0; ra = {5'(r1), 5'(r0)};
    reset = 1;
    m_reset();
    #1 check_all();
    chk("pend_async_clr", 64'(pend_a), 64'd0);
    @(negedge clk);
    reset = 0;
  endtask

  function automatic int pick();
    return ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
  endfunction

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 0;

    step(0, 0, 0, 0, 0, 5, 31);
    // write-first forwarding, then the stored value
    step(1, 3, 64'hDEAD, 0, 0, 3, 31);
    step(0, 0, 0, 0, 0, 3, 3);
    // zero register ignores writes
    step(1, 31, 64'hFFFF, 0, 0, 31, 3);
    step(0, 0, 0, 0, 0, 31, 31);
    // RAW/WAW on r7
    step(0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 1, 7, 7, 0);
    step(1, 7, 64'h77, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 7, 0);
    // fill the outstanding-write budget
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, i, i, 0);
    step(0, 0, 0, 1, 5, 1, 5);
    step(1, 1, 64'h11, 1, 5, 1, 5);
    step(0, 0, 0, 0, 0, 1, 5);
    // same-cycle retire and re-issue of r9
    step(1, 2, 64'h22, 0, 0, 2, 9);
    step(0, 0, 0, 1, 9, 9, 0);
    step(1, 9, 64'h99, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 9, 4);
    do_reset(9, 3);
    step(0, 0, 0, 0, 0, 9, 3);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset(pick(), pick());
      else step($urandom_range(0, 1) == 1, pick(), {$urandom, $urandom},
                $urandom_range(0, 9) < 6, pick(), pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
